// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte-stream sources.
// A grant is held for a whole packet; bytes pass through a one-entry output register.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  output logic [ID_W-1:0]           tx_src,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      dbg_state_o
);

  // Handshakes: a byte moves on a rising clk edge when valid & ready are both high;
  // valid/data must hold until then, and ready may depend combinationally on the consumer.

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W:0]    NREQ_W  = (ID_W + 1)'(NUM_REQ);

  logic [0:0]        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]   tx_src_q, tx_src_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W:0]     idx_w;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              accept;

  // Search starts just after the previous winner so every source gets its turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx_w      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_w = {1'b0, last_grant_q} + (ID_W + 1)'(k);
      if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
      if (!pick_found && req_valid[idx_w[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = idx_w[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LOCK) req_ready[grant_q] = ~tx_valid_q | tx_ready;
  end

  assign accept = (state_q == LOCK) & sel_valid & (~tx_valid_q | tx_ready);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_src_d     = tx_src_q;
    if (tx_valid_q & tx_ready) tx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sel_data;
          tx_src_d   = grant_q;
          cnt_d      = '0;
          if (sel_last) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // A stalled source loses its grant once TIMEOUT idle cycles have elapsed.
          if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_src_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_src_q     <= tx_src_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_src      = tx_src_q;
  assign busy        = (state_q == LOCK) | tx_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, packets, round-robin, backpressure,
// timeout release and wrap/skip arbitration, all with hand-computed expectations.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [1:0]  tx_src;
  logic        tx_ready;
  logic        busy;
  logic        dbg_state;

  int n_checks;
  int n_pass;
  int ptr [4];
  logic [3:0]  acc;
  logic [11:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_src     (tx_src),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;

    // Reset values
    step(); #2;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_src", tx_src, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    step(); rst = 1'b0;

    // Single three-byte packet from requester 0
    req_valid = 4'b0001; set_byte(0, 8'haa); req_last = 4'b0000; tx_ready = 1'b1;
    #2 chk("sp_idle_state", dbg_state, 0);
    chk("sp_idle_ready", req_ready, 0);
    step(); #2;
    chk("sp_grant_ready", req_ready, 4'b0001);
    chk("sp_grant_busy", busy, 1);
    step(); set_byte(0, 8'h33); #2;
    chk("sp_b0_valid", tx_valid, 1);
    chk("sp_b0_data", tx_data, 8'haa);
    chk("sp_b0_src", tx_src, 0);
    step(); set_byte(0, 8'h3c); req_last = 4'b0001; #2;
    chk("sp_b1_data", tx_data, 8'h33);
    step(); req_valid = '0; req_last = '0; #2;
    chk("sp_b2_data", tx_data, 8'h3c);
    chk("sp_end_state", dbg_state, 0);
    chk("sp_end_busy", busy, 1);
    step(); #2;
    chk("sp_drain_valid", tx_valid, 0);
    chk("sp_drain_busy", busy, 0);

    // Backpressure: requester 1 holds 8'h55 for five stalled cycles
    step(); req_valid = 4'b0010; set_byte(1, 8'h55); req_last = '0; #2;
    chk("bp_idle_ready", req_ready, 0);
    step(); #2;
    chk("bp_grant_ready", req_ready, 4'b0010);
    step(); tx_ready = 1'b0; set_byte(1, 8'h66); req_last = 4'b0010; #2;
    chk("bp_hold0_data", tx_data, 8'h55);
    chk("bp_hold0_ready", req_ready, 0);
    for (int i = 1; i < 5; i++) begin
      step(); #2;
      chk("bp_hold_data", tx_data, 8'h55);
      chk("bp_hold_valid", tx_valid, 1);
      chk("bp_hold_ready", req_ready, 0);
    end
    step(); tx_ready = 1'b1; #2;
    chk("bp_release_ready", req_ready, 4'b0010);
    chk("bp_release_data", tx_data, 8'h55);
    step(); req_valid = '0; req_last = '0; #2;
    chk("bp_next_data", tx_data, 8'h66);
    chk("bp_next_src", tx_src, 1);
    chk("bp_next_valid", tx_valid, 1);
    step(); #2;
    chk("bp_drain_valid", tx_valid, 0);

    // Reset while a byte is held in the output register
    step(); req_valid = 4'b1000; set_byte(3, 8'hc5); req_last = 4'b1000; tx_ready = 1'b0; #2;
    chk("mr_idle_state", dbg_state, 0);
    step(); #2;
    chk("mr_grant_ready", req_ready, 4'b1000);
    step(); req_valid = '0; req_last = '0; #2;
    chk("mr_held_valid", tx_valid, 1);
    chk("mr_held_data", tx_data, 8'hc5);
    chk("mr_held_src", tx_src, 3);
    #1 rst = 1'b1;
    #1;
    chk("mr_rst_valid", tx_valid, 0);
    chk("mr_rst_data", tx_data, 0);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_state", dbg_state, 0);
    step(); rst = 1'b0; tx_ready = 1'b1;

    // Round-robin: all four requesters with two 2-byte packets each
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++)
        for (int b = 0; b < 2; b++)
          exp_q.push_back({4'(i), 4'(i), 4'(p * 2 + b)});
    for (int i = 0; i < 4; i++) ptr[i] = 0;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = (ptr[i] < 4);
        set_byte(i, {4'(i), 4'(ptr[i])});
        req_last[i] = ptr[i][0];
      end
      #2;
      if (tx_valid) chk("rr_byte", {2'b00, tx_src, tx_data}, exp_q.pop_front());
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < 4; i++) if (acc[i]) ptr[i]++;
    end
    chk("rr_left", exp_q.size(), 0);

    // Wrap and skip: last winner 3, only requester 2 asks, then 0 and 2
    req_valid = 4'b0100; set_byte(2, 8'h5a); req_last = 4'b0100; #2;
    chk("ws_idle_state", dbg_state, 0);
    step(); #2;
    chk("ws_grant2", req_ready, 4'b0100);
    step(); req_valid = 4'b0101; set_byte(0, 8'h11); set_byte(2, 8'h77); req_last = 4'b0101; #2;
    chk("ws_b5a_data", tx_data, 8'h5a);
    chk("ws_b5a_src", tx_src, 2);
    chk("ws_single_end", dbg_state, 0);
    step(); #2;
    chk("ws_grant0", req_ready, 4'b0001);
    step(); req_valid = 4'b0100; req_last = 4'b0100; #2;
    chk("ws_b11_data", tx_data, 8'h11);
    chk("ws_b11_src", tx_src, 0);
    step(); #2;
    chk("ws_regrant2", req_ready, 4'b0100);
    step(); req_valid = '0; req_last = '0; #2;
    chk("ws_b77_data", tx_data, 8'h77);
    chk("ws_b77_src", tx_src, 2);
    step(); #2;
    chk("ws_drain_busy", busy, 0);

    // Timeout: requester 1 stalls mid-packet while requester 2 waits
    step(); req_valid = 4'b0010; set_byte(1, 8'h9e); req_last = '0; #2;
    chk("to_idle_state", dbg_state, 0);
    step(); #2;
    chk("to_grant1", req_ready, 4'b0010);
    step(); req_valid = 4'b0100; set_byte(2, 8'hd2); req_last = 4'b0100; #2;
    chk("to_b9e_data", tx_data, 8'h9e);
    chk("to_b9e_src", tx_src, 1);
    chk("to_wait0_state", dbg_state, 1);
    chk("to_wait0_ready", req_ready, 4'b0010);
    for (int i = 1; i < 8; i++) begin
      step(); #2;
      chk("to_wait_state", dbg_state, 1);
      chk("to_wait_ready", req_ready, 4'b0010);
    end
    step(); #2;
    chk("to_release_state", dbg_state, 0);
    chk("to_release_ready", req_ready, 0);
    step(); #2;
    chk("to_grant2_state", dbg_state, 1);
    chk("to_grant2_ready", req_ready, 4'b0100);
    step(); req_valid = '0; req_last = '0; #2;
    chk("to_bd2_data", tx_data, 8'hd2);
    chk("to_bd2_src", tx_src, 2);
    step(); #2;
    chk("to_drain_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
